// File: rtl/core_if_fetch.sv
// Instruction fetch stage: single-outstanding imem requests feeding a 2-entry queue to decode.
// Optional CORE_IF_BYPASS_EN forwards a response straight to decode when the queue is empty.
module core_if_fetch #(
   parameter int                   CORE_XLEN       = 32,
   parameter int                   CORE_INST_WIDTH = 32,
   parameter logic [CORE_XLEN-1:0] RESET_PC        = 32'h8000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       o_imem_req,
   output logic [CORE_XLEN-1:0]       o_imem_addr,
   input  logic                       i_imem_gnt,
   input  logic                       i_imem_rsp_valid,
   input  logic [CORE_INST_WIDTH-1:0] i_imem_rsp_data,
   input  logic                       i_imem_rsp_err,
   output logic                       o_if_valid,
   output logic [CORE_INST_WIDTH-1:0] o_if_inst,
   output logic [CORE_XLEN-1:0]       o_if_pc,
   output logic                       o_if_err,
   input  logic                       i_id_ready,
   input  logic                       i_flush,
   input  logic [CORE_XLEN-1:0]       i_flush_pc
);

   typedef enum logic {S_REQ = 1'b0, S_RSP = 1'b1} state_t;

   typedef struct packed {
      logic [CORE_XLEN-1:0]       pc;
      logic [CORE_INST_WIDTH-1:0] inst;
      logic                       err;
   } entry_t;

   state_t               state, state_nxt;
   logic [CORE_XLEN-1:0] fetch_pc;
   logic [CORE_XLEN-1:0] req_pc;
   logic                 discard;
   entry_t               q [2];
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           count;

   logic   fire, rsp_in, rsp_keep, push, pop, q_full, q_empty;
   entry_t rsp_entry, head, out;

   assign q_full    = (count == 2'd2);
   assign q_empty   = (count == 2'd0);
   assign fire      = o_imem_req & i_imem_gnt;
   assign rsp_in    = (state == S_RSP) & i_imem_rsp_valid;
   assign rsp_keep  = rsp_in & ~discard & ~i_flush;
   assign rsp_entry = '{pc: req_pc, inst: i_imem_rsp_data, err: i_imem_rsp_err};
   assign head      = q[rd_ptr];
   assign pop       = ~q_empty & i_id_ready & ~i_flush;

`ifdef CORE_IF_BYPASS_EN
   logic bypass;
   // An empty queue hands the response to decode in the same cycle; it is only
   // stored if decode does not take it right away.
   assign bypass     = rsp_keep & q_empty;
   assign out        = bypass ? rsp_entry : head;
   assign o_if_valid = ~q_empty | bypass;
   assign push       = rsp_keep & ~(bypass & i_id_ready);
`else
   assign out        = head;
   assign o_if_valid = ~q_empty;
   assign push       = rsp_keep;
`endif

   assign o_if_inst = out.inst;
   assign o_if_pc   = out.pc;
   assign o_if_err  = out.err;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_REQ;
      else        state <= state_nxt;
   end

   // Flush needs no special case: REQ cannot fire under flush, and RSP leaves
   // only when the response shows up (dropped or not).
   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (fire) state_nxt = S_RSP;
         S_RSP:   if (i_imem_rsp_valid) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   always_comb begin
      o_imem_req  = (state == S_REQ) & ~q_full & ~i_flush;
      o_imem_addr = fetch_pc;
   end

   // ---------------- fetch pc / discard ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else if (i_flush) begin
         fetch_pc <= i_flush_pc & ~CORE_XLEN'(3);
      end else if (fire) begin
         fetch_pc <= fetch_pc + CORE_XLEN'(4);
         req_pc   <= fetch_pc;
      end
   end

   // The in-flight response after a flush belongs to the old stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            discard <= 1'b0;
      else if (rsp_in)                       discard <= 1'b0;
      else if (i_flush && state == S_RSP)    discard <= 1'b1;
   end

   // ---------------- 2-entry queue ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q[0]   <= '0;
         q[1]   <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (i_flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            q[wr_ptr] <= rsp_entry;
            wr_ptr    <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_core_if_fetch.sv
// Randomized bench for core_if_fetch: bench acts as imem and checks against a queue-level model.
module tb_core_if_fetch;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rsp_valid;
   logic [31:0] i_imem_rsp_data;
   logic        i_imem_rsp_err;
   logic        o_if_valid;
   logic [31:0] o_if_inst;
   logic [31:0] o_if_pc;
   logic        o_if_err;
   logic        i_id_ready;
   logic        i_flush;
   logic [31:0] i_flush_pc;

   always #5 clk = ~clk;

   core_if_fetch dut (
      .clk(clk), .rst_n(rst_n),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
      .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
      .i_imem_rsp_err(i_imem_rsp_err),
      .o_if_valid(o_if_valid), .o_if_inst(o_if_inst), .o_if_pc(o_if_pc), .o_if_err(o_if_err),
      .i_id_ready(i_id_ready), .i_flush(i_flush), .i_flush_pc(i_flush_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } ent_t;

   ent_t        q[$];          // entries decode should still see, in order
   logic [31:0] exp_pc;        // next fetch address
   logic [31:0] out_addr;      // address of the granted, unanswered request
   bit          outst, stale;
   int          wait_cnt;
   int          n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return a[5:2] == 4'd5;
   endfunction

   function automatic logic [31:0] pick_flush_pc();
      case ($urandom_range(3))
         0:       return 32'h8000_0102;
         1:       return 32'hFFFF_FFF8;
         2:       return 32'hFFFF_FFFC;
         default: return $urandom;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_imem_gnt = 1'b0; i_imem_rsp_valid = 1'b0; i_flush = 1'b0; i_id_ready = 1'b0;
      #1;
      chk("rst_req",   o_imem_req,  32'd1);
      chk("rst_addr",  o_imem_addr, RPC);
      chk("rst_valid", o_if_valid,  32'd0);
      chk("rst_inst",  o_if_inst,   32'd0);
      chk("rst_pc",    o_if_pc,     32'd0);
      chk("rst_err",   o_if_err,    32'd0);
      q.delete();
      outst = 0; stale = 0; wait_cnt = 0;
      exp_pc = RPC;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle: pf/pr/pg are percent chances of flush, ready, gnt.
   task automatic step(input int pf, input int pr, input int pg);
      bit   fl, rdy, g, rv, exp_req, exp_vld, byp, byp_taken;
      ent_t head, rent;
      @(negedge clk);
      fl  = ($urandom_range(99) < pf);
      rdy = ($urandom_range(99) < pr);
      g   = ($urandom_range(99) < pg);
      rv  = 1'b0;
      if (outst) begin
         if (wait_cnt == 0) rv = 1'b1;
         else wait_cnt--;
      end else if ($urandom_range(99) < 5) begin
         rv = 1'b1;   // stray response with nothing granted
      end
      rent.pc   = out_addr;
      rent.inst = mem_word(out_addr);
      rent.err  = mem_err(out_addr);
      i_flush          = fl;
      i_flush_pc       = fl ? pick_flush_pc() : $urandom;
      i_id_ready       = rdy;
      i_imem_gnt       = g;
      i_imem_rsp_valid = rv;
      i_imem_rsp_data  = outst ? rent.inst : 32'hDEAD_BEEF;
      i_imem_rsp_err   = outst ? rent.err : 1'($urandom_range(1));
      byp = 1'b0;
`ifdef CORE_IF_BYPASS_EN
      byp = outst & rv & ~stale & ~fl & (q.size() == 0);
`endif
      exp_req = ~outst & (q.size() < 2) & ~fl;
      exp_vld = (q.size() != 0) | byp;
      #1;
      chk("imem_req",  o_imem_req,  32'(exp_req));
      chk("imem_addr", o_imem_addr, exp_pc);
      chk("if_valid",  o_if_valid,  32'(exp_vld));
      if (exp_vld) begin
         head = byp ? rent : q[0];
         chk("if_pc",   o_if_pc,   head.pc);
         chk("if_inst", o_if_inst, head.inst);
         chk("if_err",  o_if_err,  32'(head.err));
      end
      // what the coming clock edge does
      if (fl) begin
         q.delete();
         exp_pc = i_flush_pc & 32'hFFFF_FFFC;
         if (outst) begin
            if (rv) begin outst = 0; stale = 0; end
            else stale = 1;
         end
      end else begin
         byp_taken = 1'b0;
         if (exp_vld && rdy) begin
            if (q.size() != 0) void'(q.pop_front());
            else byp_taken = 1'b1;
         end
         if (outst && rv) begin
            if (!stale && !byp_taken) q.push_back(rent);
            outst = 0; stale = 0;
         end
         if (exp_req && g) begin
            outst    = 1;
            out_addr = exp_pc;
            exp_pc   = exp_pc + 32'd4;
            wait_cnt = $urandom_range(2);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      i_imem_gnt = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0; i_imem_rsp_err = 1'b0;
      i_id_ready = 1'b0; i_flush = 1'b0; i_flush_pc = '0;
      out_addr = '0;
      do_reset();
      repeat (300) step(0, 100, 100);    // streaming
      repeat (15)  step(0, 0, 100);      // decode stalled, queue fills
      repeat (20)  step(0, 100, 100);
      repeat (400) step(0, 30, 70);      // back-pressure
      repeat (600) step(8, 70, 70);      // redirects
      repeat (37)  step(5, 50, 90);
      do_reset();                        // reset mid-operation
      repeat (600) step(12, 50, 50);
      repeat (300) step(3, 90, 90);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
